// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits
// that share one BCD-to-segment decoder. A prescaler divides clk into digit
// slots. Each slot hands the shared decoder one digit's code and pulls that
// digit's enable low.
//
// The display value is double-buffered. A load is parked in a shadow register
// and only becomes visible at the frame boundary, which is the slot tick that
// wraps from the last digit back to digit 0. This prevents tearing mid-frame.
//
// Optional leading-zero blanking replaces zero digits above the most
// significant non-zero digit with the blank code 4'hF. Digit 0 is never
// blanked.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous reset, active-low
//   load        in   capture value/blank_lz this cycle
//   value       in   4*NUM_DIGITS digit codes, nibble k = digit k
//   blank_lz    in   leading-zero blanking request, captured with value
//   bcd         out  code for the shared decoder (4'hF = blank)
//   digit_n     out  active-low digit enables, at most one low
//   frame_done  out  one-cycle pulse on each frame boundary
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   digit_n,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  logic [PRE_W-1:0]      r_pre_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [VAL_W-1:0]      r_shadow;
  logic                  r_shadow_lz;
  logic                  r_pending;
  logic [VAL_W-1:0]      r_active;
  logic                  r_lz_act;
  logic [3:0]            r_bcd;
  logic [NUM_DIGITS-1:0] r_digit_n;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_last_idx;
  logic                  w_boundary;
  logic                  w_take;
  logic [IDX_W-1:0]      w_idx_next;
  logic [VAL_W-1:0]      w_active_next;
  logic                  w_lz_next;
  logic [3:0]            w_bcd_next;
  logic [NUM_DIGITS-1:0] w_digit_n_next;
  logic [3:0]            w_nib;
  logic                  w_zero_run;

  always_comb begin
    w_tick     = (r_pre_cnt == PRE_W'(TICK_DIV - 1));
    w_last_idx = (r_idx == IDX_W'(NUM_DIGITS - 1));
    w_boundary = w_tick && w_last_idx;
    w_idx_next = w_last_idx ? '0 : r_idx + IDX_W'(1);

    // A load in the boundary cycle itself bypasses the shadow, so digit 0 of
    // the new frame already shows it.
    w_take        = w_boundary && (r_pending || load);
    w_active_next = r_active;
    w_lz_next     = r_lz_act;
    if (w_take) begin
      w_active_next = load ? value : r_shadow;
      w_lz_next     = load ? blank_lz : r_shadow_lz;
    end
  end

  // Walk from the most significant digit down. w_zero_run stays set while
  // every nibble seen so far (this one included) is zero, which is exactly
  // the leading-zero condition for the current digit.
  always_comb begin
    w_bcd_next     = 4'hF;
    w_digit_n_next = '1;
    w_nib          = 4'h0;
    w_zero_run     = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_nib      = w_active_next[4*k +: 4];
      w_zero_run = w_zero_run && (w_nib == 4'h0);
      if (w_idx_next == IDX_W'(k)) begin
        w_digit_n_next[k] = 1'b0;
        w_bcd_next        = (w_lz_next && w_zero_run && (k != 0)) ? 4'hF : w_nib;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre_cnt    <= '0;
      r_idx        <= IDX_W'(NUM_DIGITS - 1);
      r_shadow     <= '0;
      r_shadow_lz  <= 1'b0;
      r_pending    <= 1'b0;
      r_active     <= '0;
      r_lz_act     <= 1'b0;
      r_bcd        <= 4'hF;
      r_digit_n    <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);

      if (load) begin
        r_shadow    <= value;
        r_shadow_lz <= blank_lz;
        r_pending   <= 1'b1;
      end
      // The boundary consumes whatever is pending, including a same-cycle load.
      if (w_boundary) begin
        r_pending <= 1'b0;
      end

      r_active     <= w_active_next;
      r_lz_act     <= w_lz_next;
      r_frame_done <= w_boundary;

      // Outputs only move on a slot tick. Until the first tick after reset
      // they keep the blank/all-off reset values.
      if (w_tick) begin
        r_idx     <= w_idx_next;
        r_bcd     <= w_bcd_next;
        r_digit_n <= w_digit_n_next;
      end
    end
  end

  assign bcd        = r_bcd;
  assign digit_n    = r_digit_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  digit_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .digit_n    (digit_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // One frame of expectations: the shown code per digit (nibble s = digit s)
  // plus up to two loads applied at given cycle offsets within the frame.
  typedef struct {
    int          ld_at;
    logic [15:0] ld_val;
    logic        ld_blz;
    int          ld2_at;
    logic [15:0] ld2_val;
    logic [15:0] exp;
  } frame_vec_t;

  frame_vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp_bcd,
                       input logic [3:0] exp_dn, input logic exp_fd);
    checks++;
    if ({frame_done, digit_n, bcd} !== {exp_fd, exp_dn, exp_bcd}) begin
      errors++;
      $display("FAIL %s: got fd=%0b digit_n=%b bcd=%h, want fd=%0b digit_n=%b bcd=%h",
               name, frame_done, digit_n, bcd, exp_fd, exp_dn, exp_bcd);
    end
  endtask

  // Entered just after a boundary edge; returns just after the next one.
  task automatic run_frame(input frame_vec_t v, input int f);
    logic [15:0] e;
    logic [3:0]  dn;
    int          s;
    e = v.exp;
    for (int i = 0; i < 16; i++) begin
      s  = i / 4;
      dn = 4'b1111;
      dn[s] = 1'b0;
      check($sformatf("frame%0d cyc%0d", f, i), e[4*s +: 4], dn, i == 0);
      if (i == v.ld_at) begin
        load = 1'b1; value = v.ld_val; blank_lz = v.ld_blz;
      end else if (i == v.ld2_at) begin
        load = 1'b1; value = v.ld2_val; blank_lz = v.ld_blz;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t idle;
    vecs[0] = '{2,  16'h1234, 1'b0, -1, 16'h0000, 16'h0000};
    vecs[1] = '{5,  16'h5678, 1'b0, -1, 16'h0000, 16'h1234};
    vecs[2] = '{15, 16'h9ABC, 1'b0, -1, 16'h0000, 16'h5678};
    vecs[3] = '{3,  16'h0050, 1'b1, -1, 16'h0000, 16'h9ABC};
    vecs[4] = '{8,  16'h0000, 1'b1, -1, 16'h0000, 16'hFF50};
    vecs[5] = '{0,  16'h0000, 1'b0, -1, 16'h0000, 16'hFFF0};
    vecs[6] = '{10, 16'h00D0, 1'b1, -1, 16'h0000, 16'h0000};
    vecs[7] = '{4,  16'h1000, 1'b1, -1, 16'h0000, 16'hFFD0};
    vecs[8] = '{3,  16'h2222, 1'b0, 9,  16'h3456, 16'h1000};
    vecs[9] = '{-1, 16'h0000, 1'b0, -1, 16'h0000, 16'h3456};
    idle    = '{-1, 16'h0000, 1'b0, -1, 16'h0000, 16'h0000};

    rst_n = 1'b0; load = 1'b0; value = 16'h0; blank_lz = 1'b0;

    // Reset held for three edges, then three blank cycles, then first boundary.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("in_reset%0d", i), 4'hF, 4'b1111, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_reset%0d", i), 4'hF, 4'b1111, 1'b0);
    end
    step();

    for (int f = 0; f < 10; f++) run_frame(vecs[f], f);

    // Reset in the middle of digit 2 with a load still pending.
    for (int i = 0; i < 10; i++) begin
      load = (i == 4);
      value = 16'h7777;
      blank_lz = 1'b0;
      step();
    end
    load = 1'b0;
    rst_n = 1'b0;
    step();
    check("mid_reset0", 4'hF, 4'b1111, 1'b0);
    step();
    check("mid_reset1", 4'hF, 4'b1111, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mid_post%0d", i), 4'hF, 4'b1111, 1'b0);
    end
    step();
    run_frame(idle, 10);
    run_frame(idle, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
